// File: rtl/analog_mux_seq_pkg.sv
// Shared types and constants for the analog mux sequencer and its one-hot decoder.
package analog_mux_seq_pkg;

  localparam int MUX_N_CH        = 16;
  localparam int MUX_GAP_DEFAULT = 4;

  typedef logic [3:0] chan_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_DWELL = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mux_onehot_dec.sv
// Combinational 4-bit channel index to one-hot mux enable decoder.
// Output is all-zero while i_en is low; the sequencer registers the result.
module mux_onehot_dec
  import analog_mux_seq_pkg::*;
#(
  parameter int N_CH = MUX_N_CH
) (
  input  logic [3:0]      i_idx,
  input  logic            i_en,
  output logic [N_CH-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      o_onehot[i] = i_en && (i_idx == 4'(i));
    end
  end

endmodule

// File: rtl/analog_mux_sequencer.sv
// Break-before-make sequencer for the 16-channel analog mux bank: manual hold or range scan.
// Build option MUX_SEQ_LOOP_EN: scan mode repeats first_ch..last_ch until stop or !ena.
module analog_mux_sequencer
  import analog_mux_seq_pkg::*;
#(
  parameter int N_CH       = MUX_N_CH,
  parameter int GAP_CYCLES = MUX_GAP_DEFAULT,
  parameter int DWELL_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ena,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_manual,
  input  logic [3:0]         i_man_sel,
  input  logic [3:0]         i_first_ch,
  input  logic [3:0]         i_last_ch,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [N_CH-1:0]    o_ctrl,
  output logic [3:0]         o_cur_ch,
  output logic               o_busy,
  output logic               o_settled,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_BREAK = ST_BREAK;
  localparam logic [1:0] S_DWELL = ST_DWELL;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [1:0]         r_state;
  logic [GAP_W-1:0]   r_gapCnt;
  logic [DWELL_W-1:0] r_dwellCnt;
  logic [DWELL_W-1:0] r_dwellCfg;
  logic               r_manual;
  logic [3:0]         r_lastCh;
`ifdef MUX_SEQ_LOOP_EN
  logic [3:0]         r_firstCh;
`endif

  logic [N_CH-1:0]    w_onehot;
  logic [DWELL_W-1:0] w_dwellLoad;

  // A dwell of zero behaves as one cycle, so the down-counter loads max(dwell,1)-1.
  assign w_dwellLoad = (r_dwellCfg == '0) ? '0 : r_dwellCfg - DWELL_W'(1);

  mux_onehot_dec #(.N_CH(N_CH)) u_dec (
    .i_idx    (o_cur_ch),
    .i_en     (r_state == S_BREAK),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gapCnt   <= '0;
      r_dwellCnt <= '0;
      r_dwellCfg <= '0;
      r_manual   <= 1'b0;
      r_lastCh   <= '0;
`ifdef MUX_SEQ_LOOP_EN
      r_firstCh  <= '0;
`endif
      o_ctrl     <= '0;
      o_cur_ch   <= '0;
      o_busy     <= 1'b0;
      o_settled  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_settled <= 1'b0;
      o_done    <= 1'b0;
      // Abort wins over every other transition once the sequencer is active.
      if (r_state != S_IDLE && (i_stop || !i_ena)) begin
        r_state <= S_IDLE;
        o_ctrl  <= '0;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            o_ctrl <= '0;
            if (i_start && i_ena && !i_stop) begin
              r_manual   <= i_manual;
              r_lastCh   <= i_last_ch;
              r_dwellCfg <= i_dwell;
`ifdef MUX_SEQ_LOOP_EN
              r_firstCh  <= i_first_ch;
`endif
              o_cur_ch   <= i_manual ? i_man_sel : i_first_ch;
              r_gapCnt   <= GAP_LOAD;
              r_state    <= S_BREAK;
              o_busy     <= 1'b1;
            end
          end
          S_BREAK: begin
            if (r_gapCnt == '0) begin
              r_state    <= S_DWELL;
              o_ctrl     <= w_onehot;
              r_dwellCnt <= w_dwellLoad;
              o_settled  <= (w_dwellLoad == '0);
            end else begin
              r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
          end
          S_DWELL: begin
            if (r_dwellCnt != '0) begin
              r_dwellCnt <= r_dwellCnt - DWELL_W'(1);
              o_settled  <= (r_dwellCnt == DWELL_W'(1));
            end else if (r_manual) begin
              r_state <= S_HOLD;
            end else begin
              o_ctrl   <= '0;
              r_gapCnt <= GAP_LOAD;
              if (o_cur_ch == r_lastCh) begin
                o_done <= 1'b1;
`ifdef MUX_SEQ_LOOP_EN
                o_cur_ch <= r_firstCh;
                r_state  <= S_BREAK;
`else
                r_state  <= S_IDLE;
                o_busy   <= 1'b0;
`endif
              end else begin
                o_cur_ch <= 4'(o_cur_ch + 4'd1);
                r_state  <= S_BREAK;
              end
            end
          end
          S_HOLD: begin
            if (i_man_sel != o_cur_ch) begin
              o_cur_ch <= i_man_sel;
              o_ctrl   <= '0;
              r_gapCnt <= GAP_LOAD;
              r_state  <= S_BREAK;
            end
          end
          default: begin
            r_state <= S_IDLE;
            o_ctrl  <= '0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_analog_mux_sequencer.sv
// Self-checking bench for analog_mux_sequencer: per-cycle comparison against a queue-based
// schedule model, plus a break-before-make gap monitor. Honours MUX_SEQ_LOOP_EN if defined.
module tb_analog_mux_sequencer;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic        stop;
  logic        manual;
  logic [3:0]  manSel;
  logic [3:0]  firstCh;
  logic [3:0]  lastCh;
  logic [7:0]  dwell;
  logic [15:0] ctrl;
  logic [3:0]  curCh;
  logic        busy;
  logic        settled;
  logic        done;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [3:0]  ch;
    logic        busy;
    logic        settled;
    logic        done;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   checks = 0;
  int   failures = 0;
  int   cycIdx;
  int   doneEdge;
  int   settledSeen;

  analog_mux_sequencer #(.N_CH(16), .GAP_CYCLES(GAP), .DWELL_W(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ena      (ena),
    .i_start    (start),
    .i_stop     (stop),
    .i_manual   (manual),
    .i_man_sel  (manSel),
    .i_first_ch (firstCh),
    .i_last_ch  (lastCh),
    .i_dwell    (dwell),
    .o_ctrl     (ctrl),
    .o_cur_ch   (curCh),
    .o_busy     (busy),
    .o_settled  (settled),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Break-before-make: a new nonzero ctrl pattern must follow at least GAP all-zero cycles.
  int          zeroRun = GAP;
  logic [15:0] lastNz = '0;
  always @(negedge clk) begin
    if (ctrl != '0) begin
      if (lastNz != '0 && ctrl != lastNz)
        checkOutput("gapInvariant", 32'(zeroRun >= GAP), 32'd1);
      lastNz = ctrl;
      zeroRun = 0;
    end else begin
      zeroRun++;
    end
  end

  function automatic logic [15:0] onehot(input logic [3:0] ch);
    logic [15:0] one;
    one = 16'h0001;
    return one << ch;
  endfunction

  function automatic int effDwell(input logic [7:0] dw);
    return (dw == 8'd0) ? 1 : int'(dw);
  endfunction

  function automatic int chanCount(input logic [3:0] f, input logic [3:0] l);
    return ((int'(l) - int'(f) + 16) % 16) + 1;
  endfunction

  task automatic pushEntry(input logic [15:0] c, input logic [3:0] ch,
                           input logic b, input logic s, input logic d);
    exp_t e;
    e.ctrl = c;
    e.ch = ch;
    e.busy = b;
    e.settled = s;
    e.done = d;
    expQ.push_back(e);
  endtask

  // One channel visit: GAP dark cycles then D lit cycles, settled on the final lit one.
  task automatic planSegment(input logic [3:0] ch, input int d, input logic doneFirst);
    for (int i = 0; i < GAP; i++) pushEntry('0, ch, 1'b1, 1'b0, doneFirst && (i == 0));
    for (int i = 0; i < d; i++) pushEntry(onehot(ch), ch, 1'b1, (i == d - 1), 1'b0);
  endtask

  task automatic planScan(input logic [3:0] f, input logic [3:0] l, input int d, input int passes);
    int n;
    n = chanCount(f, l);
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++) planSegment(4'((int'(f) + k) % 16), d, (p > 0) && (k == 0));
`ifdef MUX_SEQ_LOOP_EN
    pushEntry('0, f, 1'b1, 1'b0, 1'b1);
`else
    pushEntry('0, l, 1'b0, 1'b0, 1'b1);
    pushEntry('0, l, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic runQueue(input int maxN);
    exp_t e;
    for (int k = 0; k < maxN && expQ.size() > 0; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      e = expQ.pop_front();
      cycIdx++;
      if (done && doneEdge < 0) doneEdge = cycIdx - 1;
      if (settled) settledSeen++;
      checkOutput($sformatf("outputs@%0d", cycIdx), 32'({ctrl, curCh, busy, settled, done}), 32'(e));
      lastExp = e;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [3:0] sel, input logic [3:0] f,
                               input logic [3:0] l, input logic [7:0] dw);
    manual = m;
    manSel = sel;
    firstCh = f;
    lastCh = l;
    dwell = dw;
    start = 1'b1;
    cycIdx = 0;
    doneEdge = -1;
    settledSeen = 0;
  endtask

  task automatic endScan();
`ifdef MUX_SEQ_LOOP_EN
    stop = 1'b1;
    pushEntry('0, lastExp.ch, 1'b0, 1'b0, 1'b0);
    runQueue(1);
`endif
  endtask

  task automatic scanTest(input logic [3:0] f, input logic [3:0] l, input logic [7:0] dw, input int passes);
    int p;
    int n;
    int d;
    p = passes;
`ifndef MUX_SEQ_LOOP_EN
    p = 1;
`endif
    n = chanCount(f, l);
    d = effDwell(dw);
    applyStimulus(1'b0, 4'd0, f, l, dw);
    planScan(f, l, d, p);
    runQueue(100000);
    checkOutput("doneLatency", 32'(doneEdge), 32'(n * (GAP + d)));
    checkOutput("settledCount", 32'(settledSeen), 32'(n * p));
    endScan();
  endtask

  task automatic manualTest(input logic [3:0] sel, input logic [3:0] newSel, input logic [7:0] dw,
                            input int holdN, input logic useEna);
    int d;
    d = effDwell(dw);
    applyStimulus(1'b1, sel, 4'd0, 4'd0, dw);
    planSegment(sel, d, 1'b0);
    repeat (holdN) pushEntry(onehot(sel), sel, 1'b1, 1'b0, 1'b0);
    runQueue(1000);
    manSel = newSel;
    start = 1'b1;
    planSegment(newSel, d, 1'b0);
    repeat (holdN) pushEntry(onehot(newSel), newSel, 1'b1, 1'b0, 1'b0);
    runQueue(1000);
    checkOutput("manualSettled", 32'(settledSeen), 32'd2);
    if (useEna) ena = 1'b0;
    else stop = 1'b1;
    pushEntry('0, newSel, 1'b0, 1'b0, 1'b0);
    pushEntry('0, newSel, 1'b0, 1'b0, 1'b0);
    runQueue(1);
    ena = 1'b1;
    runQueue(1);
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    manual = 1'b0;
    manSel = '0;
    firstCh = '0;
    lastCh = '0;
    dwell = '0;
    cycIdx = 0;
    doneEdge = -1;
    settledSeen = 0;
    lastExp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState", 32'({ctrl, curCh, busy, settled, done}), 32'd0);
    rst = 1'b0;
    repeat (2) pushEntry('0, 4'd0, 1'b0, 1'b0, 1'b0);
    runQueue(2);

    // Directed scans: full range, then a wrapping range with zero dwell.
    scanTest(4'd0, 4'd15, 8'd10, 1);
    scanTest(4'd14, 4'd1, 8'd0, 1);

    manualTest(4'd3, 4'd9, 8'd2, 3, 1'b0);

    // Simultaneous start and stop in IDLE must do nothing.
    applyStimulus(1'b0, 4'd0, 4'd2, 4'd4, 8'd3);
    stop = 1'b1;
    repeat (3) pushEntry('0, lastExp.ch, 1'b0, 1'b0, 1'b0);
    runQueue(3);

    // Stop mid-scan: dark next cycle, no done pulse.
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd15, 8'd3);
    planScan(4'd0, 4'd15, 3, 1);
    runQueue(30);
    expQ.delete();
    stop = 1'b1;
    repeat (3) pushEntry('0, lastExp.ch, 1'b0, 1'b0, 1'b0);
    runQueue(3);
    checkOutput("noDoneAfterStop", 32'(doneEdge), 32'hffffffff);

    // Reset while channel 5 is lit.
    applyStimulus(1'b0, 4'd0, 4'd5, 4'd5, 8'd10);
    planScan(4'd5, 4'd5, 10, 1);
    runQueue(GAP + 3);
    expQ.delete();
    rst = 1'b1;
    pushEntry('0, 4'd0, 1'b0, 1'b0, 1'b0);
    runQueue(1);
    rst = 1'b0;
    repeat (3) pushEntry('0, 4'd0, 1'b0, 1'b0, 1'b0);
    runQueue(3);

`ifdef MUX_SEQ_LOOP_EN
    scanTest(4'd2, 4'd3, 8'd1, 3);
`endif

    for (int it = 0; it < 6; it++) begin
      scanTest(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)), 2);
    end
    for (int it = 0; it < 4; it++) begin
      logic [3:0] s0;
      s0 = 4'($urandom_range(0, 15));
      manualTest(s0, 4'(s0 + 4'($urandom_range(1, 15))), 8'($urandom_range(0, 3)),
                 $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
